// File: rtl/me_unit_if.sv
// EX->ME, SRAM read-data, ME->WB and ME->ID signals of the memory-access stage.
// The slave modport is the ME stage; the master modport is its environment.
interface me_unit_if;
  logic        EX_to_ME_Valid;
  logic [70:0] EX_to_ME_Bus;
  logic        ME_Allow_in;
  logic [31:0] data_sram_rdata;
  logic        WB_Allow_in;
  logic        ME_to_WB_Valid;
  logic [69:0] ME_to_WB_Bus;
  logic [4:0]  ME_dest;
  logic [31:0] ME_Forward_Res;
  logic        ME_to_ID_Ld_busy;

  modport slave (
    input  EX_to_ME_Valid, EX_to_ME_Bus, data_sram_rdata, WB_Allow_in,
    output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest,
           ME_Forward_Res, ME_to_ID_Ld_busy
  );

  modport master (
    output EX_to_ME_Valid, EX_to_ME_Bus, data_sram_rdata, WB_Allow_in,
    input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest,
           ME_Forward_Res, ME_to_ID_Ld_busy
  );
endinterface

// File: rtl/me_unit.sv
// LoongArch ME stage: latches the EX bus, merges one-cycle SRAM load data, offers to WB.
// Optional macro ME_LOAD_FWD_EN forwards load data to ID instead of raising a load-busy stall.
module me_unit (
  input logic      clk,
  input logic      reset,
  me_unit_if.slave io
);
  // Handshake: a transfer happens on a rising edge where the producer's valid
  // and the consumer's allow-in are both high; valid never waits on allow-in.
  logic        me_valid;
  logic        first_cycle;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] rdata_hold;

  logic        ready_go;
  logic        allow_in;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign ready_go = 1'b1;
  assign allow_in = !me_valid || (ready_go && io.WB_Allow_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      me_valid     <= 1'b0;
      first_cycle  <= 1'b0;
      pc           <= 32'd0;
      alu_result   <= 32'd0;
      res_from_mem <= 1'b0;
      gr_we        <= 1'b0;
      dest         <= 5'd0;
      rdata_hold   <= 32'd0;
    end else begin
      if (allow_in) begin
        me_valid    <= io.EX_to_ME_Valid;
        first_cycle <= io.EX_to_ME_Valid;
        if (io.EX_to_ME_Valid) begin
          {pc, alu_result, res_from_mem, gr_we, dest} <= io.EX_to_ME_Bus;
        end
      end else begin
        first_cycle <= 1'b0;
      end
      // EX re-drives the SRAM every cycle, so keep what arrived in the first cycle.
      if (first_cycle) begin
        rdata_hold <= io.data_sram_rdata;
      end
    end
  end

  assign load_data    = first_cycle ? io.data_sram_rdata : rdata_hold;
  assign final_result = res_from_mem ? load_data : alu_result;

  assign io.ME_Allow_in    = allow_in;
  assign io.ME_to_WB_Valid = me_valid && ready_go;
  assign io.ME_to_WB_Bus   = me_valid ? {pc, final_result, gr_we, dest} : 70'd0;
  assign io.ME_dest        = dest & {5{me_valid}};

`ifdef ME_LOAD_FWD_EN
  assign io.ME_Forward_Res   = me_valid ? final_result : 32'd0;
  assign io.ME_to_ID_Ld_busy = 1'b0;
`else
  assign io.ME_Forward_Res   = me_valid ? alu_result : 32'd0;
  assign io.ME_to_ID_Ld_busy = me_valid && res_from_mem;
`endif
endmodule

// File: tb/tb_me_unit.sv
// Bench for me_unit: directed test-plan steps followed by random traffic,
// all checked against a slot-level reference model and a WB-order scoreboard.
module tb_me_unit;
  logic clk;
  logic reset;
  me_unit_if bus_if();

  me_unit dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one instruction slot; a load's value is fixed by the
  // SRAM data seen during its first ME cycle.
  logic        m_valid;
  logic        m_fresh;
  logic [31:0] m_pc, m_alu, m_data;
  logic        m_ld, m_we;
  logic [4:0]  m_dest;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [70:0] mk_bus(input logic [31:0] p, input logic [31:0] a,
                                         input logic ld, input logic we, input logic [4:0] d);
    return {p, a, ld, we, d};
  endfunction

  function automatic logic [31:0] model_result();
    if (!m_ld) return m_alu;
    return m_fresh ? bus_if.data_sram_rdata : m_data;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_fresh = 1'b0; m_pc = '0; m_alu = '0; m_data = '0;
    m_ld = 1'b0; m_we = 1'b0; m_dest = '0;
    exp_q.delete();
  endtask

  task automatic drive(input logic exv, input logic [70:0] b, input logic [31:0] rd, input logic wba);
    @(negedge clk);
    bus_if.EX_to_ME_Valid  = exv;
    bus_if.EX_to_ME_Bus    = b;
    bus_if.data_sram_rdata = rd;
    bus_if.WB_Allow_in     = wba;
    #1;
  endtask

  task automatic check_model();
    logic [69:0] exp_bus;
    logic [36:0] exp_id;
    exp_bus = m_valid ? {m_pc, model_result(), m_we, m_dest} : 70'd0;
    check("allow_in", 70'(bus_if.ME_Allow_in), 70'(!m_valid || bus_if.WB_Allow_in));
    check("wb_valid", 70'(bus_if.ME_to_WB_Valid), 70'(m_valid));
    check("wb_bus", bus_if.ME_to_WB_Bus, exp_bus);
    check("me_dest", 70'(bus_if.ME_dest), 70'(m_valid ? m_dest : 5'd0));
`ifdef ME_LOAD_FWD_EN
    check("fwd_res", 70'(bus_if.ME_Forward_Res), 70'(m_valid ? model_result() : 32'd0));
    check("ld_busy", 70'(bus_if.ME_to_ID_Ld_busy), 70'd0);
`else
    check("fwd_res", 70'(bus_if.ME_Forward_Res), 70'(m_valid ? m_alu : 32'd0));
    check("ld_busy", 70'(bus_if.ME_to_ID_Ld_busy), 70'(m_valid && m_ld));
`endif
    if (m_valid && bus_if.WB_Allow_in) begin
      if (exp_q.size() == 0) begin
        check("wb_order_empty", 70'(exp_q.size()), 70'd1);
      end else begin
        exp_id = exp_q.pop_front();
        check("wb_order", 70'({bus_if.ME_to_WB_Bus[69:38], bus_if.ME_to_WB_Bus[4:0]}), 70'(exp_id));
      end
    end
  endtask

  task automatic tick();
    logic allow;
    @(posedge clk);
    allow = !m_valid || bus_if.WB_Allow_in;
    if (m_valid && m_fresh) m_data = bus_if.data_sram_rdata;
    m_fresh = 1'b0;
    if (allow) begin
      m_valid = bus_if.EX_to_ME_Valid;
      if (bus_if.EX_to_ME_Valid) begin
        {m_pc, m_alu, m_ld, m_we, m_dest} = bus_if.EX_to_ME_Bus;
        m_fresh = 1'b1;
        exp_q.push_back({bus_if.EX_to_ME_Bus[70:39], bus_if.EX_to_ME_Bus[4:0]});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_if.EX_to_ME_Valid  = 1'b0;
    bus_if.EX_to_ME_Bus    = '0;
    bus_if.data_sram_rdata = '0;
    bus_if.WB_Allow_in     = 1'b1;
    model_reset();
    #1;
    check("rst_allow", 70'(bus_if.ME_Allow_in), 70'd1);
    check("rst_wb_valid", 70'(bus_if.ME_to_WB_Valid), 70'd0);
    check("rst_wb_bus", bus_if.ME_to_WB_Bus, 70'd0);
    check("rst_dest", 70'(bus_if.ME_dest), 70'd0);
    check("rst_fwd", 70'(bus_if.ME_Forward_Res), 70'd0);
    check("rst_ld_busy", 70'(bus_if.ME_to_ID_Ld_busy), 70'd0);
    @(negedge clk);
    reset = 1'b0;

    // ALU op
    drive(1'b1, mk_bus(32'h1C000000, 32'h12345678, 1'b0, 1'b1, 5'd5), 32'h0, 1'b1);
    check_model(); tick();
    drive(1'b0, '0, 32'hAAAA5555, 1'b1);
    check_model();
    check("alu_wb_valid", 70'(bus_if.ME_to_WB_Valid), 70'd1);
    check("alu_result", 70'(bus_if.ME_to_WB_Bus[37:6]), 70'h12345678);
    check("alu_dest", 70'(bus_if.ME_dest), 70'd5);
    tick();

    // Load without stall
    drive(1'b1, mk_bus(32'h1C000004, 32'h00001000, 1'b1, 1'b1, 5'd6), 32'h0, 1'b1);
    check_model(); tick();
    drive(1'b0, '0, 32'hDEADBEEF, 1'b1);
    check_model();
    check("ld_result", 70'(bus_if.ME_to_WB_Bus[37:6]), 70'hDEADBEEF);
    check("ld_allow", 70'(bus_if.ME_Allow_in), 70'd1);
    tick();

    // Load to r7 under a three-cycle WB stall, with a new instruction waiting in EX
    drive(1'b1, mk_bus(32'h1C000008, 32'h00002000, 1'b1, 1'b1, 5'd7), 32'h0, 1'b1);
    check_model(); tick();
    drive(1'b1, mk_bus(32'h1C00000C, 32'h0BADF00D, 1'b0, 1'b1, 5'd8), 32'hDEADBEEF, 1'b0);
    check_model();
    check("stall0_result", 70'(bus_if.ME_to_WB_Bus[37:6]), 70'hDEADBEEF);
    check("stall0_allow", 70'(bus_if.ME_Allow_in), 70'd0);
`ifdef ME_LOAD_FWD_EN
    check("fwd_load", 70'(bus_if.ME_Forward_Res), 70'hDEADBEEF);
    check("fwd_busy", 70'(bus_if.ME_to_ID_Ld_busy), 70'd0);
`else
    check("fwd_load", 70'(bus_if.ME_Forward_Res), 70'h00002000);
    check("fwd_busy", 70'(bus_if.ME_to_ID_Ld_busy), 70'd1);
`endif
    tick();
    drive(1'b1, mk_bus(32'h1C00000C, 32'h0BADF00D, 1'b0, 1'b1, 5'd8), 32'h00000000, 1'b0);
    check_model();
    check("stall1_result", 70'(bus_if.ME_to_WB_Bus[37:6]), 70'hDEADBEEF);
    check("stall1_allow", 70'(bus_if.ME_Allow_in), 70'd0);
    tick();
    drive(1'b1, mk_bus(32'h1C00000C, 32'h0BADF00D, 1'b0, 1'b1, 5'd8), 32'hFFFFFFFF, 1'b0);
    check_model();
    check("stall2_result", 70'(bus_if.ME_to_WB_Bus[37:6]), 70'hDEADBEEF);
    check("stall2_allow", 70'(bus_if.ME_Allow_in), 70'd0);
    tick();
    drive(1'b1, mk_bus(32'h1C00000C, 32'h0BADF00D, 1'b0, 1'b1, 5'd8), 32'h55555555, 1'b1);
    check_model();
    check("release_result", 70'(bus_if.ME_to_WB_Bus[37:6]), 70'hDEADBEEF);
    check("release_allow", 70'(bus_if.ME_Allow_in), 70'd1);
    tick();
    drive(1'b0, '0, 32'h0, 1'b1);
    check_model();
    check("next_result", 70'(bus_if.ME_to_WB_Bus[37:6]), 70'h0BADF00D);
    tick();

    // Back-to-back loads A then B
    drive(1'b1, mk_bus(32'h1C000010, 32'h100, 1'b1, 1'b1, 5'd10), 32'h0, 1'b1);
    check_model(); tick();
    drive(1'b1, mk_bus(32'h1C000014, 32'h104, 1'b1, 1'b1, 5'd11), 32'h11111111, 1'b1);
    check_model();
    check("b2b_a_result", 70'(bus_if.ME_to_WB_Bus[37:6]), 70'h11111111);
    check("b2b_a_pc", 70'(bus_if.ME_to_WB_Bus[69:38]), 70'h1C000010);
    tick();
    drive(1'b0, '0, 32'h22222222, 1'b1);
    check_model();
    check("b2b_b_valid", 70'(bus_if.ME_to_WB_Valid), 70'd1);
    check("b2b_b_result", 70'(bus_if.ME_to_WB_Bus[37:6]), 70'h22222222);
    check("b2b_b_pc", 70'(bus_if.ME_to_WB_Bus[69:38]), 70'h1C000014);
    tick();

    // Asynchronous reset while a load is held by a WB stall
    drive(1'b1, mk_bus(32'h1C000018, 32'h200, 1'b1, 1'b1, 5'd9), 32'h0, 1'b1);
    check_model(); tick();
    drive(1'b0, '0, 32'hCAFEF00D, 1'b0);
    check_model(); tick();
    drive(1'b0, '0, 32'h12121212, 1'b0);
    check_model();
    reset = 1'b1;
    #1;
    check("arst_wb_valid", 70'(bus_if.ME_to_WB_Valid), 70'd0);
    check("arst_dest", 70'(bus_if.ME_dest), 70'd0);
    check("arst_allow", 70'(bus_if.ME_Allow_in), 70'd1);
    #1;
    reset = 1'b0;
    model_reset();
    tick();
    drive(1'b0, '0, 32'h0, 1'b1);
    check_model();
    check("post_rst_wb_valid", 70'(bus_if.ME_to_WB_Valid), 70'd0);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            mk_bus($urandom(), $urandom(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))),
            $urandom(), ($urandom_range(0, 3) != 0));
      check_model();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
